// File: rtl/lab2_proc_skid_pkg.sv
// Shared types and constants for the lab2 processor skid-buffer stage.
// State encoding doubles as the occupancy count, so the helper is a plain lookup.
package lab2_proc_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [1:0] occupancy(input skid_state_t s);
        logic [1:0] n;
        n = OCC_EMPTY;
        case (s)
            ONE:     n = OCC_ONE;
            TWO:     n = OCC_TWO;
            default: n = OCC_EMPTY;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lab2_proc_skid_entry.sv
// One storage slot of the skid buffer: an enabled data register.
// Cleared on reset only so that traces start from a known value.
module lab2_proc_skid_entry #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lab2_proc_skid_stage.sv
// Two-entry val/rdy skid buffer between the operand-select stage and the next stage.
// in_rdy is decoded from the state register alone, cutting the ready path upstream.
module lab2_proc_skid_stage
    import lab2_proc_skid_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    input  logic               squash,
    output logic [1:0]         num_entries
);

    skid_state_t        state;
    logic               in_fire;
    logic               out_fire;
    logic               head_en;
    logic               skid_en;
    logic [p_nbits-1:0] head_d;
    logic [p_nbits-1:0] head_q;
    logic [p_nbits-1:0] skid_q;

    assign in_rdy      = (state != TWO);
    assign out_val     = (state != EMPTY);
    assign num_entries = occupancy(state);
    assign out_msg     = head_q;

    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;

    // Squashed cycles never load data; the buffer is emptied anyway.
    always_comb begin
        head_en = 1'b0;
        skid_en = 1'b0;
        head_d  = in_msg;
        if (!squash) begin
            case (state)
                EMPTY: head_en = in_fire;
                ONE: begin
                    head_en = in_fire & out_fire;
                    skid_en = in_fire & ~out_fire;
                end
                TWO: begin
                    head_en = out_fire;
                    head_d  = skid_q;
                end
                default: begin
                    head_en = 1'b0;
                    skid_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else if (squash) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state <= ONE;
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state <= TWO;
                    end else if (!in_fire && out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (out_fire) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    lab2_proc_skid_entry #(.p_nbits(p_nbits)) head_entry (
        .clk   (clk),
        .reset (reset),
        .en    (head_en),
        .d     (head_d),
        .q     (head_q)
    );

    lab2_proc_skid_entry #(.p_nbits(p_nbits)) skid_entry (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_msg),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_lab2_proc_skid_stage.sv
// Bench for lab2_proc_skid_stage: a queue model of the buffer contents, checked every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_lab2_proc_skid_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [31:0] in_msg = '0;
    logic        out_val;
    logic        out_rdy = 1'b0;
    logic [31:0] out_msg;
    logic        squash = 1'b0;
    logic [1:0]  num_entries;

    int compared = 0;
    int mismatched = 0;
    bit checking = 1'b0;
    logic [31:0] model_q[$];

    lab2_proc_skid_stage #(.p_nbits(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_msg      (in_msg),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_msg     (out_msg),
        .squash      (squash),
        .num_entries (num_entries)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: the model queue says what the stage must be holding.
    always @(negedge clk) begin
        if (checking && !reset) begin
            check_output("model_in_rdy", {31'd0, in_rdy}, (model_q.size() < 2) ? 32'd1 : 32'd0);
            check_output("model_out_val", {31'd0, out_val}, (model_q.size() > 0) ? 32'd1 : 32'd0);
            check_output("model_num_entries", {30'd0, num_entries}, model_q.size());
            if (model_q.size() > 0) begin
                check_output("model_out_msg", out_msg, model_q[0]);
            end
        end
    end

    // Advance one edge: update the model from the inputs seen at that edge, then drive new ones.
    task automatic applyStimulus(input logic iv, input logic [31:0] im, input logic ordy, input logic sq);
        bit in_f;
        bit out_f;
        @(posedge clk);
        in_f  = in_val && (model_q.size() < 2);
        out_f = out_rdy && (model_q.size() > 0);
        if (squash) begin
            model_q.delete();
        end else begin
            if (out_f) void'(model_q.pop_front());
            if (in_f) model_q.push_back(in_msg);
        end
        #1;
        in_val  = iv;
        in_msg  = im;
        out_rdy = ordy;
        squash  = sq;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
        check_output("reset_out_val", {31'd0, out_val}, 32'd0);
        check_output("reset_out_msg", out_msg, 32'd0);
        check_output("reset_num_entries", {30'd0, num_entries}, 32'd0);
        reset = 1'b0;
        model_q.delete();
        checking = 1'b1;

        // Streaming at full rate
        applyStimulus(1, 32'h11, 1, 0);
        applyStimulus(1, 32'h22, 1, 0);
        check_output("stream_msg0", out_msg, 32'h11);
        applyStimulus(1, 32'h33, 1, 0);
        check_output("stream_msg1", out_msg, 32'h22);
        check_output("stream_in_rdy", {31'd0, in_rdy}, 32'd1);
        applyStimulus(0, 32'h0, 1, 0);
        check_output("stream_msg2", out_msg, 32'h33);
        check_output("stream_num", {30'd0, num_entries}, 32'd1);
        applyStimulus(0, 32'h0, 1, 0);
        check_output("stream_drained", {31'd0, out_val}, 32'd0);

        // Backpressure fills skid, then drains in order
        applyStimulus(1, 32'hA0, 0, 0);
        applyStimulus(1, 32'hA1, 0, 0);
        applyStimulus(1, 32'hA2, 0, 0);
        check_output("bp_num_full", {30'd0, num_entries}, 32'd2);
        check_output("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
        check_output("bp_head", out_msg, 32'hA0);
        applyStimulus(1, 32'hA2, 1, 0);
        applyStimulus(1, 32'hA2, 1, 0);
        check_output("bp_second", out_msg, 32'hA1);
        check_output("bp_num_one", {30'd0, num_entries}, 32'd1);
        applyStimulus(0, 32'h0, 1, 0);
        check_output("bp_third", out_msg, 32'hA2);
        applyStimulus(0, 32'h0, 1, 0);
        check_output("bp_empty", {31'd0, out_val}, 32'd0);

        // Squash while full, with a competing input
        applyStimulus(1, 32'h5, 0, 0);
        applyStimulus(1, 32'h6, 0, 0);
        applyStimulus(1, 32'h7, 0, 1);
        check_output("sq_full_num", {30'd0, num_entries}, 32'd2);
        applyStimulus(0, 32'h0, 0, 0);
        check_output("sq_out_val", {31'd0, out_val}, 32'd0);
        check_output("sq_num", {30'd0, num_entries}, 32'd0);
        applyStimulus(0, 32'h0, 1, 0);
        check_output("sq_still_empty", {31'd0, out_val}, 32'd0);

        // Simultaneous in/out fire in ONE
        applyStimulus(1, 32'h10, 0, 0);
        applyStimulus(1, 32'h20, 1, 0);
        check_output("sim_head", out_msg, 32'h10);
        applyStimulus(0, 32'h0, 0, 0);
        check_output("sim_next", out_msg, 32'h20);
        check_output("sim_num", {30'd0, num_entries}, 32'd1);
        applyStimulus(0, 32'h0, 1, 0);

        // Asynchronous reset while full
        applyStimulus(1, 32'h1, 0, 0);
        applyStimulus(1, 32'h2, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);
        check_output("ar_full", {30'd0, num_entries}, 32'd2);
        #1 reset = 1'b1;
        #1;
        check_output("ar_out_val", {31'd0, out_val}, 32'd0);
        check_output("ar_in_rdy", {31'd0, in_rdy}, 32'd1);
        check_output("ar_num", {30'd0, num_entries}, 32'd0);
        check_output("ar_out_msg", out_msg, 32'd0);
        #1 reset = 1'b0;
        model_q.delete();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom,
                          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        @(negedge clk);
        check_output("final_empty", {31'd0, out_val}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
